ps2_receiver: RTL and testbench
===============================

Name: ps2_receiver

Overview:
- PS/2 keyboard receive front-end.
- Samples the keyboard's open-collector clock/data lines in the system clock domain and deframes 11-bit device-to-host frames.
- Folds the E0 (extended) and F0 (break) prefixes into a single 10-bit key-event word, presented with a one-cycle ready strobe.
- Sits between the board PS/2 pins and the game/control logic that decodes movement keys.

Parameters:
- TIMEOUT_CYCLES, 20000, idle clk cycles without a ps2_clk falling edge mid-frame before the partial frame is discarded (200 us at 100 MHz).
- SYNC_STAGES, 2, synchronizer flip-flops on each PS/2 input before edge detection.

Ports:
- clk  input  1  system clock (100 MHz nominal).
- rst  input  1  asynchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock line, asynchronous.
- ps2_data  input  1  raw PS/2 data line, asynchronous.
- data  output  10  last key event: [9]=break, [8]=extended, [7:0]=scan code.
- ready  output  1  one-cycle strobe, asserted when data has just been updated.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: data=10'h000, ready=0, bit counter=0, shift register=0, break/extended flags=0, timeout counter=0.
- Synchronization: ps2_clk and ps2_data each pass through SYNC_STAGES flops.
- Edge detection: a falling edge is a synchronized ps2_clk of 1 in the previous cycle and 0 in the current cycle.
- Sampling: ps2_data is sampled on each falling edge.
- Frame format: 11 bits, in order — start (0), 8 data bits LSB first, odd parity, stop (1).
- Bit counter: counts 0..10 and returns to 0 after the stop bit.
- Start bit: a start bit of 1 is ignored and the counter stays at 0. This resynchronizes on idle-high noise.
- Frame check at the stop bit: valid when start=0, odd parity over data+parity bits, and stop=1.
- Invalid frame: discarded, and both prefix flags are cleared. No ready; data unchanged.
- Valid frame, byte F0: set the break flag, no ready.
- Valid frame, byte E0: set the extended flag, no ready.
- Valid frame, any other byte: data <= {break, extended, byte}; ready=1 for exactly one clk; both flags cleared.
- Latency: data and ready update in the clk cycle after the stop-bit falling edge is detected.
- data holds its value until the next accepted code.
- Timeout: while bit counter != 0, count clk cycles since the last falling edge. Reaching TIMEOUT_CYCLES resets the bit counter to 0; prefix flags are kept. The counter is cleared on every falling edge and whenever the bit counter is 0.
- ready never asserts on two consecutive cycles.
- Sequence E0 F0 xx yields data={1,1,xx}.
- Reset mid-frame: all state returns to reset values immediately; the partial frame is lost.
- No host-to-device transmission; both lines are input-only.

Decomposition:
- Shared package ps2_pkg:
  - PS2_BREAK_PREFIX = 8'hF0
  - PS2_EXT_PREFIX = 8'hE0
  - PS2_FRAME_BITS = 11
  - localparam key-code constants consumed downstream: 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h5A.
- One sub-module: ps2_sync_edge.
  - Synchronizes both lines.
  - Outputs the synchronized data bit and a one-cycle falling-edge pulse of ps2_clk.
- The deframer, prefix handling and timeout stay in ps2_receiver.

Test Plan:
- Make code: send frame 0x1D (parity bit 1) at 12.5 kHz PS/2 clock -> single ready pulse, data=10'h01D; data still 10'h01D 1 ms later.
- Break: send F0 then 1D -> no ready after F0; one ready after 1D with data=10'h21D.
- Extended: send E0 75 -> data=10'h175. Then send E0 F0 75 -> data=10'h375. Exactly one ready per sequence.
- Bad parity: send 0x23 with parity flipped -> no ready, data unchanged. Then a valid 0x23 -> data=10'h023.
- Timeout: send start plus 4 data bits, hold ps2_clk high > TIMEOUT_CYCLES, then a full frame 0x29 -> data=10'h029, exactly one ready.
- Reset: assert rst after 6 bits of a frame -> data=0 and ready=0 immediately. After release, a full frame 0x5A -> data=10'h05A.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, the key-event word layout and the frame check.
package ps2_pkg;

   localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
   localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
   localparam int         PS2_FRAME_BITS   = 11;

   // Scan codes (set 2) decoded by the movement/control logic.
   localparam logic [7:0] KEY_W     = 8'h1D;
   localparam logic [7:0] KEY_A     = 8'h1C;
   localparam logic [7:0] KEY_S     = 8'h1B;
   localparam logic [7:0] KEY_D     = 8'h23;
   localparam logic [7:0] KEY_SPACE = 8'h29;
   localparam logic [7:0] KEY_I     = 8'h43;
   localparam logic [7:0] KEY_J     = 8'h3B;
   localparam logic [7:0] KEY_K     = 8'h42;
   localparam logic [7:0] KEY_L     = 8'h4B;
   localparam logic [7:0] KEY_ENTER = 8'h5A;

   typedef struct packed {
      logic       brk;
      logic       ext;
      logic [7:0] code;
   } key_event_t;

   // frame[0]=start, frame[8:1]=data LSB first, frame[9]=parity, frame[10]=stop
   function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] frame);
      return !frame[0] && frame[10] && (^frame[9:1]);
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings the PS/2 lines into the clk domain and flags ps2_clk falling edges.
module ps2_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic data_sync,
   output logic clk_fall
);

   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
   logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
   logic                   clk_prev_q, clk_prev_d;

   always_comb begin
      clk_sync_d     = clk_sync_q;
      data_sync_d    = data_sync_q;
      clk_sync_d[0]  = ps2_clk;
      data_sync_d[0] = ps2_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         clk_sync_d[i]  = clk_sync_q[i-1];
         data_sync_d[i] = data_sync_q[i-1];
      end
      clk_prev_d = clk_sync_q[SYNC_STAGES-1];
   end

   // Reset to the idle-high bus level so leaving reset never fakes an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_q  <= '1;
         data_sync_q <= '1;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_sync_q  <= clk_sync_d;
         data_sync_q <= data_sync_d;
         clk_prev_q  <= clk_prev_d;
      end
   end

   assign data_sync = data_sync_q[SYNC_STAGES-1];
   assign clk_fall  = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host deframer folding E0/F0 prefixes into a 10-bit key event.
module ps2_receiver
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 20000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [9:0] data,
   output logic       ready
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic                      sdata, fall;
   logic [3:0]                bit_cnt_q, bit_cnt_d;
   logic [PS2_FRAME_BITS-2:0] shift_q, shift_d;
   logic                      brk_q, brk_d, ext_q, ext_d;
   key_event_t                data_q, data_d;
   logic                      ready_q, ready_d;
   logic [TW-1:0]             tmo_q, tmo_d;
   logic [PS2_FRAME_BITS-1:0] frame;

   ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .data_sync (sdata),
      .clk_fall  (fall)
   );

   // Bits shift in from the top, so after ten shifts shift_q[0] is the start bit.
   assign frame = {sdata, shift_q};

   always_comb begin
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      brk_d     = brk_q;
      ext_d     = ext_q;
      data_d    = data_q;
      ready_d   = 1'b0;
      tmo_d     = '0;
      if (fall) begin
         if (bit_cnt_q == '0) begin
            // A high start bit is idle noise; stay put until a real start.
            if (!sdata) begin
               shift_d   = {sdata, shift_q[PS2_FRAME_BITS-2:1]};
               bit_cnt_d = 4'd1;
            end
         end else if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) begin
            bit_cnt_d = '0;
            if (!ps2_frame_ok(frame)) begin
               brk_d = 1'b0;
               ext_d = 1'b0;
            end else if (frame[8:1] == PS2_BREAK_PREFIX) begin
               brk_d = 1'b1;
            end else if (frame[8:1] == PS2_EXT_PREFIX) begin
               ext_d = 1'b1;
            end else begin
               data_d  = '{brk: brk_q, ext: ext_q, code: frame[8:1]};
               ready_d = 1'b1;
               brk_d   = 1'b0;
               ext_d   = 1'b0;
            end
         end else begin
            shift_d   = {sdata, shift_q[PS2_FRAME_BITS-2:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else if (bit_cnt_q != '0) begin
         // Stalled mid-frame: drop the partial frame but keep any prefix seen.
         if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) bit_cnt_d = '0;
         else                                  tmo_d     = tmo_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt_q <= '0;
         shift_q   <= '0;
         brk_q     <= 1'b0;
         ext_q     <= 1'b0;
         data_q    <= '0;
         ready_q   <= 1'b0;
         tmo_q     <= '0;
      end else begin
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         brk_q     <= brk_d;
         ext_q     <= ext_d;
         data_q    <= data_d;
         ready_q   <= ready_d;
         tmo_q     <= tmo_d;
      end
   end

   assign data  = data_q;
   assign ready = ready_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Randomized PS/2 frame bench with a scoreboard of expected key events.
module tb_ps2_receiver;
   import ps2_pkg::*;

   localparam int TMO  = 300;
   localparam int HALF = 20;

   logic       clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic [9:0] data;
   logic       ready;

   always #5 clk = ~clk;

   ps2_receiver #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .data     (data),
      .ready    (ready)
   );

   // Reference model: prefix flags plus the queue of events the keyboard should produce.
   logic [9:0] exp_q[$];
   logic       m_brk = 1'b0, m_ext = 1'b0;
   logic [9:0] m_last = '0;

   // Hold-check requests handed to the monitor (main owns req_*, monitor owns done_cnt).
   int         req_cnt = 0;
   logic [9:0] req_val = '0;
   string      req_name = "";
   bit         done = 1'b0;

   int pass_cnt = 0, total_cnt = 0;

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ps2_bit(input logic b);
      ps2_data = b;
      wait_clk(HALF / 2);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
      wait_clk(HALF / 2);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
      logic [10:0] f;
      logic        par;
      par = ~(^b) ^ bad_par;
      f   = {~bad_stop, par, b, 1'b0};
      if (bad_par || bad_stop) begin
         m_brk = 1'b0;
         m_ext = 1'b0;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else begin
         m_last = {m_brk, m_ext, b};
         exp_q.push_back(m_last);
         m_brk = 1'b0;
         m_ext = 1'b0;
      end
      for (int i = 0; i < 11; i++) ps2_bit(f[i]);
      ps2_data = 1'b1;
      wait_clk(30);
   endtask

   task automatic send_partial(input int nbits);
      ps2_bit(1'b0);
      for (int i = 1; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
      ps2_data = 1'b1;
   endtask

   task automatic check_hold(input string name, input logic [9:0] v);
      req_name = name;
      req_val  = v;
      req_cnt++;
      wait_clk(3);
   endtask

   task automatic summary;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
   endtask

   initial begin : monitor
      int         done_cnt = 0;
      int         cyc = 0;
      logic       prev_rdy = 1'b0;
      logic [9:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (ready) begin
            total_cnt++;
            if (prev_rdy) $display("FAIL ready_consecutive: ready=1 prev=1 required prev=0");
            else pass_cnt++;
            total_cnt++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_ready: data=%h, no event expected", data);
            end else begin
               e = exp_q.pop_front();
               if (data == e) pass_cnt++;
               else $display("FAIL event_data: got %h required %h", data, e);
            end
         end
         prev_rdy = ready;
         if (req_cnt != done_cnt) begin
            done_cnt++;
            total_cnt++;
            if ({ready, data} == {1'b0, req_val}) pass_cnt++;
            else $display("FAIL %s: ready=%b data=%h required ready=0 data=%h",
                          req_name, ready, data, req_val);
         end
         if (done) begin
            total_cnt++;
            if (exp_q.size() == 0) pass_cnt++;
            else $display("FAIL missing_ready: %0d events never presented, required 0", exp_q.size());
            summary();
            $finish;
         end
         if (cyc > 95000) begin
            total_cnt++;
            $display("FAIL watchdog: cycle budget %0d exhausted", cyc);
            summary();
            $finish;
         end
      end
   end

   initial begin : stim
      logic [7:0] codes[12];
      logic [7:0] b;
      codes = '{KEY_W, KEY_A, KEY_S, KEY_D, KEY_SPACE, KEY_I, KEY_J, KEY_K,
                KEY_L, KEY_ENTER, 8'hF0, 8'hE0};
      wait_clk(3);
      check_hold("reset_state", 10'h000);
      rst = 1'b0;
      wait_clk(5);

      send_byte(8'h1D, 0, 0);
      wait_clk(500);
      check_hold("make_hold", 10'h01D);

      send_byte(8'hF0, 0, 0);
      send_byte(8'h1D, 0, 0);
      check_hold("break", 10'h21D);

      send_byte(8'hE0, 0, 0);
      send_byte(8'h75, 0, 0);
      check_hold("extended", 10'h175);
      send_byte(8'hE0, 0, 0);
      send_byte(8'hF0, 0, 0);
      send_byte(8'h75, 0, 0);
      check_hold("ext_break", 10'h375);

      send_byte(8'h23, 1, 0);
      check_hold("bad_parity", 10'h375);
      send_byte(8'h23, 0, 0);
      check_hold("after_bad_parity", 10'h023);

      send_byte(8'hF0, 0, 0);
      send_byte(8'h42, 0, 1);
      send_byte(8'h1C, 0, 0);
      check_hold("bad_stop_clears_prefix", 10'h01C);

      send_partial(5);
      wait_clk(TMO + 100);
      send_byte(8'h29, 0, 0);
      check_hold("timeout", 10'h029);

      send_byte(8'hE0, 0, 0);
      send_partial(3);
      wait_clk(TMO + 100);
      send_byte(8'h1C, 0, 0);
      check_hold("timeout_keeps_prefix", 10'h11C);

      send_byte(8'hF0, 0, 0);
      send_partial(6);
      #3 rst = 1'b1;
      m_brk  = 1'b0;
      m_ext  = 1'b0;
      m_last = '0;
      check_hold("reset_mid_frame", 10'h000);
      rst = 1'b0;
      wait_clk(5);
      send_byte(8'h5A, 0, 0);
      check_hold("after_reset", 10'h05A);

      for (int n = 0; n < 40; n++) begin
         b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : codes[$urandom_range(0, 11)];
         send_byte(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
         if (n % 4 == 3) check_hold("random_hold", m_last);
      end

      wait_clk(20);
      done = 1'b1;
   end

endmodule
